// File: rtl/lif_neuron_scheduler_if.sv
// Host-side bundle for the LIF neuron scheduler: sweep handshake, per-sweep inputs and results.
interface lif_neuron_scheduler_if #(
    parameter int N_NEURONS = 4,
    parameter int n_stage   = 10
);
    localparam int W     = n_stage + 2;
    localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    logic                     start;
    logic [2:0]               shift;
    logic signed [W-1:0]      threshold;
    logic [N_NEURONS*W-1:0]   current;
    logic [IDX_W-1:0]         u_rd_idx;
    logic signed [W-1:0]      u_rd;
    logic [N_NEURONS-1:0]     spikes;
    logic                     busy;
    logic                     done;

    modport master (
        output start, shift, threshold, current, u_rd_idx,
        input  u_rd, spikes, busy, done
    );

    modport slave (
        input  start, shift, threshold, current, u_rd_idx,
        output u_rd, spikes, busy, done
    );
endinterface

// File: rtl/lif_neuron_scheduler.sv
// Leaky integrate-and-fire scheduler: one shared decay datapath swept neuron by neuron per start.
//   state | meaning
//   IDLE  | waiting for start, inputs are latched on acceptance
//   DECAY | beta = u[i] minus its shifted leak
//   INTEG | beta + current[i], saturated to [0, max]
//   FIRE  | threshold compare, spike and reset-by-subtraction, advance i
//   DONE  | one-cycle done pulse, busy still high
module lif_neuron_scheduler #(
    parameter int N_NEURONS = 4,
    parameter int n_stage   = 10
) (
    input logic clk,
    input logic reset,
    lif_neuron_scheduler_if.slave bus
);
    localparam int W     = n_stage + 2;
    localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_NEURONS - 1);
    localparam logic signed [W-1:0] U_MAX    = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [2:0] {IDLE, DECAY, INTEG, FIRE, DONE} state_t;

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic signed [W-1:0]    u_mem [N_NEURONS];
    logic [2:0]             shift_q;
    logic signed [W-1:0]    threshold_q;
    logic [N_NEURONS*W-1:0] current_q;
    logic signed [W-1:0]    beta_q;
    logic signed [W-1:0]    sum_q;
    logic [N_NEURONS-1:0]   spikes_q;
    logic                   busy_q;
    logic                   done_q;

    logic signed [W-1:0]    u_cur;
    logic signed [W-1:0]    cur_i;
    logic signed [W-1:0]    beta_d;
    logic signed [W:0]      sum_wide;
    logic signed [W-1:0]    sum_clamped;
    logic signed [W:0]      residue_wide;
    logic signed [W-1:0]    residue_clamped;
    logic                   fire;
    logic signed [W-1:0]    u_rd_val;

    always_comb begin
        u_cur = '0;
        cur_i = '0;
        for (int k = 0; k < N_NEURONS; k++) begin
            if (idx == IDX_W'(k)) begin
                u_cur = u_mem[k];
                cur_i = current_q[k*W +: W];
            end
        end
    end

    // Shared decay datapath; stored potentials are non-negative so the logical shift is exact.
    assign beta_d = (shift_q == 3'd0) ? u_cur : u_cur - (u_cur >> shift_q);

    assign sum_wide     = {beta_q[W-1], beta_q} + {cur_i[W-1], cur_i};
    assign residue_wide = {sum_q[W-1], sum_q} - {threshold_q[W-1], threshold_q};
    assign fire         = (sum_q >= threshold_q);

    always_comb begin
        if (sum_wide[W])
            sum_clamped = '0;
        else if (sum_wide[W-1])
            sum_clamped = U_MAX;
        else
            sum_clamped = sum_wide[W-1:0];
    end

    always_comb begin
        if (residue_wide[W])
            residue_clamped = '0;
        else if (residue_wide[W-1])
            residue_clamped = U_MAX;
        else
            residue_clamped = residue_wide[W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            for (int k = 0; k < N_NEURONS; k++) u_mem[k] <= '0;
            shift_q     <= '0;
            threshold_q <= '0;
            current_q   <= '0;
            beta_q      <= '0;
            sum_q       <= '0;
            spikes_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shift_q     <= bus.shift;
                        threshold_q <= bus.threshold;
                        current_q   <= bus.current;
                        spikes_q    <= '0;
                        idx         <= '0;
                        busy_q      <= 1'b1;
                        state       <= DECAY;
                    end
                end
                DECAY: begin
                    beta_q <= beta_d;
                    state  <= INTEG;
                end
                INTEG: begin
                    sum_q <= sum_clamped;
                    state <= FIRE;
                end
                FIRE: begin
                    for (int k = 0; k < N_NEURONS; k++) begin
                        if (idx == IDX_W'(k)) begin
                            u_mem[k] <= fire ? residue_clamped : sum_q;
                            if (fire) spikes_q[k] <= 1'b1;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= DECAY;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        u_rd_val = '0;
        for (int k = 0; k < N_NEURONS; k++) begin
            if (bus.u_rd_idx == IDX_W'(k)) u_rd_val = u_mem[k];
        end
    end

    assign bus.u_rd   = u_rd_val;
    assign bus.spikes = spikes_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_lif_neuron_scheduler.sv
// Bench for lif_neuron_scheduler: transaction-level neuron model checked every cycle, plus literal pins.
module tb_lif_neuron_scheduler;
    localparam int N    = 4;
    localparam int W    = 12;
    localparam int UMAX = 2047;

    logic clk = 1'b0;
    logic reset;

    lif_neuron_scheduler_if #(.N_NEURONS(N), .n_stage(10)) bus ();

    lif_neuron_scheduler #(.N_NEURONS(N), .n_stage(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: on acceptance, every neuron's outcome is computed from the rules with plain integers,
    // then revealed at the cycle it is due (neuron i after 3(i+1) edges).
    int       exp_u [N] = '{default: 0};
    int       new_u [N] = '{default: 0};
    bit [N-1:0] new_spk  = '0;
    bit [N-1:0] exp_spk  = '0;
    bit       exp_busy = 1'b0;
    bit       exp_done = 1'b0;
    int       cyc = 0;

    function automatic int clampu(input int v);
        if (v < 0) return 0;
        if (v > UMAX) return UMAX;
        return v;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N; k++) exp_u[k] = 0;
            exp_spk  = '0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            cyc      = 0;
        end else if (!exp_busy) begin
            if (bus.start === 1'b1) begin
                for (int k = 0; k < N; k++) begin
                    int sh, thr, cur, beta, s;
                    sh   = int'(bus.shift);
                    thr  = int'($signed(bus.threshold));
                    cur  = int'($signed(bus.current[k*W +: W]));
                    beta = (sh == 0) ? exp_u[k] : exp_u[k] - (exp_u[k] / (1 << sh));
                    s    = clampu(beta + cur);
                    new_spk[k] = (s >= thr);
                    new_u[k]   = (s >= thr) ? clampu(s - thr) : s;
                end
                exp_busy = 1'b1;
                exp_spk  = '0;
                cyc      = 0;
            end
        end else begin
            cyc++;
            if (cyc == 3*N + 1) begin
                exp_busy = 1'b0;
                exp_done = 1'b0;
            end else if (cyc % 3 == 0) begin
                exp_u[cyc/3 - 1] = new_u[cyc/3 - 1];
                if (new_spk[cyc/3 - 1]) exp_spk[cyc/3 - 1] = 1'b1;
                if (cyc == 3*N) exp_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy",   32'(bus.busy),   32'(exp_busy));
        chk("cyc_done",   32'(bus.done),   32'(exp_done));
        chk("cyc_spikes", 32'(bus.spikes), 32'(exp_spk));
        chk("cyc_u_rd",   32'(bus.u_rd),   32'(exp_u[bus.u_rd_idx]));
    end

    task automatic set_in(input int sh, input int thr, input int c0, input int c1, input int c2, input int c3);
        bus.shift     = 3'(sh);
        bus.threshold = 12'(thr);
        bus.current   = {12'(c3), 12'(c2), 12'(c1), 12'(c0)};
    endtask

    task automatic check_u(input int k, input int val);
        bus.u_rd_idx = 2'(k);
        #1;
        chk("u_rd", 32'(bus.u_rd), 32'(val));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Returns edges from the accepting edge until done is observed.
    task automatic run_sweep(output int lat);
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("done_seen", 32'(bus.done), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int n;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.u_rd_idx = '0;
        set_in(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_busy",   32'(bus.busy),   32'd0);
        chk("rst_spikes", 32'(bus.spikes), 32'd0);
        for (int k = 0; k < N; k++) check_u(k, 0);

        // integrate and fire, no decay
        set_in(0, 250, 100, 0, 0, 0);
        run_sweep(lat);
        check_u(0, 100);
        chk("int_spk1", 32'(bus.spikes), 32'd0);
        run_sweep(lat);
        check_u(0, 200);
        run_sweep(lat);
        check_u(0, 50);
        chk("int_spk3", 32'(bus.spikes), 32'b0001);
        chk("done_latency", 32'(lat), 32'(3*N));

        // reset mid-sweep
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_busy",   32'(bus.busy),   32'd0);
        chk("midrst_done",   32'(bus.done),   32'd0);
        chk("midrst_spikes", 32'(bus.spikes), 32'd0);
        for (int k = 0; k < N; k++) check_u(k, 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (12) @(posedge clk);
        #1 chk("midrst_after", 32'(bus.busy), 32'd0);

        // decay
        set_in(0, 2047, 0, 1000, 0, 0);
        run_sweep(lat);
        check_u(1, 1000);
        set_in(1, 2047, 0, 0, 0, 0);
        run_sweep(lat);
        check_u(1, 500);
        run_sweep(lat);
        check_u(1, 250);
        set_in(3, 2047, 0, 0, 0, 0);
        run_sweep(lat);
        check_u(1, 219);

        // clamping
        set_in(0, 2047, 0, 0, 1500, 0);
        run_sweep(lat);
        check_u(2, 1500);
        chk("clamp_spk1", 32'(bus.spikes), 32'd0);
        run_sweep(lat);
        check_u(2, 0);
        chk("clamp_spk2", 32'(bus.spikes), 32'b0100);
        check_u(1, 219);
        set_in(0, 2047, 0, 0, 0, 100);
        run_sweep(lat);
        check_u(3, 100);
        set_in(0, 2047, 0, 0, 0, -500);
        run_sweep(lat);
        check_u(3, 0);
        chk("clamp_neg_spk", 32'(bus.spikes), 32'd0);

        // handshake with start held, threshold 0 on the first sweep
        do_reset();
        set_in(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1;
        chk("hs_busy_e0", 32'(bus.busy), 32'd1);
        for (int k = 1; k <= 28; k++) begin
            @(posedge clk); #1;
            if (k == 1) set_in(0, 2047, 5, 5, 5, 5);
            if (k == 12) begin
                chk("hs_done", 32'(bus.done), 32'd1);
                chk("hs_busy_done", 32'(bus.busy), 32'd1);
            end
            if (k == 13) begin
                chk("hs_idle1", 32'(bus.busy), 32'd0);
                chk("thr0_spikes", 32'(bus.spikes), 32'b1111);
                for (int j = 0; j < N; j++) check_u(j, 0);
            end
            if (k == 14) chk("hs_start2", 32'(bus.busy), 32'd1);
            if (k == 27) begin
                chk("hs_idle2", 32'(bus.busy), 32'd0);
                chk("hs_spikes2", 32'(bus.spikes), 32'd0);
                for (int j = 0; j < N; j++) check_u(j, 5);
            end
            if (k == 28) begin
                chk("hs_start3", 32'(bus.busy), 32'd1);
                bus.start = 1'b0;
            end
        end
        n = 0;
        while (bus.busy !== 1'b0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hs_end", 32'(bus.busy), 32'd0);
        for (int j = 0; j < N; j++) check_u(j, 10);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/lif_neuron_scheduler.md
# lif_neuron_scheduler

Time-multiplexes one shared `decay_potential` datapath across `N_NEURONS` leaky integrate-and-fire neurons. On each `start` pulse it performs one timestep sweep, neuron by neuron:
- decay the stored membrane potential;
- integrate the neuron's input current;
- compare against the threshold, emitting a spike and resetting by subtraction.

It owns the potential register file and the spike vector, and sits between the input-current source and the spike consumer.

## Interface
- `N_NEURONS`, 4, number of neurons sharing the datapath (≥1)
- `n_stage`, 10, potential width is W = n_stage+2 bits, signed
- `clk`  input  1  clock, rising edge
- `reset`  input  1  asynchronous, active-high; clears all state
- `start`  input  1  request one timestep sweep; accepted only in IDLE
- `shift`  input  3  decay setting passed to the datapath (0 = no decay, k = subtract u>>k)
- `threshold`  input  W  signed firing threshold
- `current`  input  N_NEURONS*W  signed input current per neuron; neuron i at bits [i*W +: W]
- `u_rd_idx`  input  clog2(N_NEURONS) (min 1)  potential readback select
- `u_rd`  output  W  potential of neuron `u_rd_idx`; combinational read of the register file; out-of-range index returns 0
- `spikes`  output  N_NEURONS  spike results of the last completed sweep
- `busy`  output  1  sweep in progress (includes DONE)
- `done`  output  1  one-cycle pulse at end of sweep

## Operation
- FSM states: IDLE, DECAY, INTEG, FIRE, DONE. Neuron index `i` is a counter running 0..N_NEURONS-1.
- **IDLE:** `start`=1 at a clock edge causes the following:
  - latch `shift`, `threshold` and `current` into shadow registers;
  - clear `spikes`, set `i`=0, `busy`=1;
  - move to DECAY.
- **DECAY:** drive the datapath with u[i] and the latched shift; register beta = u[i] - (u[i]>>shift) → INTEG.
- **INTEG:** sum = beta + current[i], computed at W+1 bits. Clamp to [0, 2^(W-1)-1]:
  - negative results → 0;
  - overflow → max.
  - Register the clamped sum → FIRE.
- **FIRE:**
  - If sum ≥ threshold (signed compare): set spikes[i]=1 and write u[i] = sum - threshold, clamped to [0, max].
  - Otherwise write u[i] = sum.
  - If i = N_NEURONS-1 → DONE; else i++ → DECAY.
- **DONE:** `done`=1 for this one cycle, then → IDLE with `busy`=0.
- Stored potentials are always non-negative, so the datapath's right shift never sees a negative operand.
- `start` is ignored in DECAY/INTEG/FIRE/DONE; it is not queued.
- Input changes mid-sweep have no effect on the sweep; only the latched copies are used.
- A threshold ≤ 0 is legal: every neuron spikes, and its potential is reduced by the subtraction and clamped.
- Potentials persist across sweeps. Only `reset` zeroes them.
- The `spikes` vector is stable from DONE until the next accepted `start`.

## Timing
- **Reset (async, immediate):**
  - state=IDLE, i=0;
  - all u[i]=0, `spikes`=0, `busy`=0, `done`=0;
  - shadow registers cleared.
- Reset asserted mid-sweep aborts the sweep, with no partial spikes retained.
- `start` sampled at edge E0 → `busy`=1 after E0.
- Neuron i's result is written at edge E0+3(i+1). `u_rd` reflects the new value after that edge.
- `done`=1 in the cycle after edge E0+3N, where N = N_NEURONS.
- `busy`=0 and `done`=0 after edge E0+3N+1. The earliest next accepted `start` is at edge E0+3N+2.
- Sweep latency is 3N+1 cycles. Throughput is one sweep per 3N+2 cycles.
- The datapath is used only in DECAY, one cycle per neuron, with no other sharing.

## Test plan
All cases use W=12 (max 2047), N=4.
- **Reset:** assert `reset` mid-sweep (after E0+4) → `busy`, `done`, `spikes`=0 immediately; `u_rd`=0 for every index; no `done` pulse follows.
- **Integration/fire, no decay:** shift=0, threshold=250, current[0]=100, others 0; three sweeps → u[0]=100, 200, then 300≥250 → spikes=4'b0001, u[0]=50; `done` exactly 13 cycles after `start`.
- **Decay:**
  - shift=0, threshold=2047, current[1]=1000: one sweep → u[1]=1000;
  - then shift=1, current=0: u[1]=500, then 250;
  - then shift=3: u[1]=219 (250-31).
- **Clamping:**
  - current[2]=1500 twice with threshold=2047: first sweep → 1500; second sweep → sum saturates to 2047 → spike, u[2]=0;
  - current[3]=-500 with u[3]=100 → u[3]=0, no spike.
- **Handshake:**
  - `start` held high continuously → sweeps begin at E0, E0+14, E0+28;
  - changing `current`/`threshold` at E0+1 does not alter the results of the sweep in progress;
  - `busy` is high through DONE.
- **Threshold edge:** threshold=0, all currents 0 → every sweep yields spikes=4'b1111 and potentials stay 0.
